// File: rtl/riscv_pkg.sv
// Shared types and constants for the riscv core memory subsystem.
// Holds the arbiter state encoding and address-decode constants.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arb_state_t;

   localparam int GPIO_SEL_BIT = 31;
   localparam int WORD_BYTES   = 4;

endpackage

// File: rtl/riscv_gpio_reg.sv
// GPIO output register with byte-0 write strobe and a read-response latch.
// Write lands at the end of the issue cycle; the read latch feeds the response cycle.
module riscv_gpio_reg #(
   parameter int GPIO_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [GPIO_W-1:0] wdata_i,
   input  logic              rd_en_i,
   output logic [GPIO_W-1:0] gpio_o,
   output logic [31:0]       rdata_o
);

   logic [GPIO_W-1:0] gpio_q, gpio_d;
   logic [31:0]       rdata_q, rdata_d;

   always_comb begin
      gpio_d  = gpio_q;
      rdata_d = rdata_q;
      if (wr_en_i) begin
         gpio_d = wdata_i;
      end
      if (rd_en_i) begin
         rdata_d               = '0;
         rdata_d[GPIO_W-1:0]   = gpio_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpio_q  <= '0;
         rdata_q <= '0;
      end else begin
         gpio_q  <= gpio_d;
         rdata_q <= rdata_d;
      end
   end

   assign gpio_o  = gpio_q;
   assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares the single-port RAM between fetch (I) and load/store (D); D has priority
// with a starvation guard for I. Also decodes the memory-mapped GPIO register.
module riscv_mem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int RAM_WORDS  = 1024,
   parameter int STARVE_MAX = 4,
   parameter int GPIO_W     = 8,
   localparam int RAM_AW    = $clog2(RAM_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_we,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_wstrb,
   output logic              d_ack,
   output logic [31:0]       d_rdata,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [GPIO_W-1:0] gpio
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   arb_state_t    state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          sel_gpio_q, sel_gpio_d;
   logic          grant_d;
   logic          d_is_gpio;
   logic          gpio_wr, gpio_rd;
   logic [31:0]   gpio_rdata;
   logic          unused_addr_bits;

   assign d_is_gpio        = d_addr[GPIO_SEL_BIT];
   assign unused_addr_bits = ^{i_addr, d_addr};

   always_comb begin
      state_d    = state_q;
      streak_d   = streak_q;
      sel_gpio_d = sel_gpio_q;
      grant_d    = 1'b0;
      ram_en     = 1'b0;
      ram_we     = '0;
      ram_addr   = i_addr[RAM_AW+1:2];
      ram_wdata  = d_wdata;
      gpio_wr    = 1'b0;
      gpio_rd    = 1'b0;
      i_ack      = 1'b0;
      d_ack      = 1'b0;
      i_rdata    = ram_rdata;
      d_rdata    = sel_gpio_q ? gpio_rdata : ram_rdata;
      case (state_q)
         IDLE: begin
            // I is forced through once D has won STARVE_MAX times in a row while I waited.
            grant_d = d_req && !(i_req && streak_q == SW'(STARVE_MAX));
            if (grant_d) begin
               state_d    = BUSY_D;
               sel_gpio_d = d_is_gpio;
               ram_addr   = d_addr[RAM_AW+1:2];
               if (i_req) begin
                  streak_d = (streak_q == SW'(STARVE_MAX)) ? streak_q : streak_q + SW'(1);
               end else begin
                  streak_d = '0;
               end
               if (d_is_gpio) begin
                  gpio_wr = d_we && d_wstrb[0];
                  gpio_rd = !d_we;
               end else begin
                  ram_en = 1'b1;
                  ram_we = d_we ? d_wstrb : 4'b0000;
               end
            end else if (i_req) begin
               state_d  = BUSY_I;
               streak_d = '0;
               ram_en   = 1'b1;
            end
         end
         BUSY_I: begin
            i_ack   = 1'b1;
            state_d = IDLE;
         end
         BUSY_D: begin
            d_ack   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         ram_en = 1'b0;
         ram_we = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         streak_q   <= '0;
         sel_gpio_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         streak_q   <= streak_d;
         sel_gpio_q <= sel_gpio_d;
      end
   end

   riscv_gpio_reg #(
      .GPIO_W(GPIO_W)
   ) u_gpio (
      .clk    (clk),
      .rst    (rst),
      .wr_en_i(gpio_wr),
      .wdata_i(d_wdata[GPIO_W-1:0]),
      .rd_en_i(gpio_rd),
      .gpio_o (gpio),
      .rdata_o(gpio_rdata)
   );

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a behavioural synchronous RAM.
module tb_riscv_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic [31:0] d_addr;
   logic        d_we;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [7:0]  gpio;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:1023];
   logic [31:0] rd;

   riscv_mem_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_ack    (i_ack),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_addr   (d_addr),
      .d_we     (d_we),
      .d_wdata  (d_wdata),
      .d_wstrb  (d_wstrb),
      .d_ack    (d_ack),
      .d_rdata  (d_rdata),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .gpio     (gpio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
         ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one D access from IDLE; returns the response-cycle read data.
   task automatic d_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic exp_en, input logic [3:0] exp_we,
                           input logic [9:0] exp_addr, output logic [31:0] rdata);
      d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata; d_wstrb = wstrb;
      #1;
      chk("d_issue_ram_en", 32'(ram_en), 32'(exp_en));
      chk("d_issue_ram_we", 32'(ram_we), 32'(exp_we));
      if (exp_en) chk("d_issue_ram_addr", 32'(ram_addr), 32'(exp_addr));
      chk("d_issue_no_ack", 32'(d_ack), 32'd0);
      step();
      chk("d_ack", 32'(d_ack), 32'd1);
      rdata = d_rdata;
      d_req = 1'b0;
      step();
      chk("d_ack_pulse", 32'(d_ack), 32'd0);
   endtask

   task automatic i_fetch(input logic [31:0] addr, input logic [9:0] exp_addr,
                          output logic [31:0] rdata);
      i_req = 1'b1; i_addr = addr;
      #1;
      chk("i_issue_ram_en", 32'(ram_en), 32'd1);
      chk("i_issue_ram_we", 32'(ram_we), 32'd0);
      chk("i_issue_ram_addr", 32'(ram_addr), 32'(exp_addr));
      step();
      chk("i_ack", 32'(i_ack), 32'd1);
      rdata = i_rdata;
      i_req = 1'b0;
      step();
      chk("i_ack_pulse", 32'(i_ack), 32'd0);
   endtask

   // Cycle 1 is the first issue cycle; masks give the cycles expected to carry acks.
   task automatic contend(input logic [20:1] imask, input logic [20:1] dmask,
                          input logic [20:1] ireq_pat);
      i_addr = 32'h14; d_addr = 32'h8; d_we = 1'b0; d_wstrb = 4'hF;
      for (int c = 1; c <= 20; c++) begin
         i_req = ireq_pat[c];
         d_req = 1'b1;
         #1;
         chk($sformatf("contend_i_ack_c%0d", c), 32'(i_ack), 32'(imask[c]));
         chk($sformatf("contend_d_ack_c%0d", c), 32'(d_ack), 32'(dmask[c]));
         if (imask[c]) chk("contend_i_rdata", i_rdata, 32'hDEADBEEF);
         step();
      end
      i_req = 1'b0; d_req = 1'b0;
      step();
   endtask

   initial begin
      for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
      mem[5] = 32'hDEADBEEF;
      ram_rdata = 32'h0;
      rst = 1'b1;
      i_req = 1'b1; i_addr = 32'h14;
      d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
      step();
      step();
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_i_ack", 32'(i_ack), 32'd0);
      chk("rst_d_ack", 32'(d_ack), 32'd0);
      chk("rst_gpio", 32'(gpio), 32'd0);
      i_req = 1'b0;
      step();
      rst = 1'b0;

      for (int c = 0; c < 20; c++) begin
         step();
         chk("idle_ram_en", 32'(ram_en), 32'd0);
         chk("idle_i_ack", 32'(i_ack), 32'd0);
         chk("idle_d_ack", 32'(d_ack), 32'd0);
      end

      i_fetch(32'h14, 10'd5, rd);
      chk("fetch_rdata", rd, 32'hDEADBEEF);

      d_access(32'h8, 1'b1, 32'h0000AB00, 4'b0010, 1'b1, 4'b0010, 10'd2, rd);
      d_access(32'h8, 1'b0, 32'h0, 4'b1111, 1'b1, 4'b0000, 10'd2, rd);
      chk("byte_write_readback", rd, 32'h0000AB00);
      d_access(32'h8, 1'b1, 32'h11223344, 4'b0001, 1'b1, 4'b0001, 10'd2, rd);
      d_access(32'h8, 1'b0, 32'h0, 4'b1111, 1'b1, 4'b0000, 10'd2, rd);
      chk("byte0_merge_readback", rd, 32'h0000AB44);

      d_access(32'h8000_0000, 1'b1, 32'h000000A5, 4'b1111, 1'b0, 4'b0000, 10'd0, rd);
      chk("gpio_after_write", 32'(gpio), 32'hA5);
      d_access(32'h8000_0000, 1'b0, 32'h0, 4'b1111, 1'b0, 4'b0000, 10'd0, rd);
      chk("gpio_readback", rd, 32'h000000A5);
      d_access(32'h8000_0000, 1'b1, 32'h0000003C, 4'b1110, 1'b0, 4'b0000, 10'd0, rd);
      chk("gpio_no_strb0_keeps", 32'(gpio), 32'hA5);

      i_fetch(32'h8000_0014, 10'd5, rd);
      chk("fetch_alias_rdata", rd, 32'hDEADBEEF);
      d_access(32'h0000_1014, 1'b0, 32'h0, 4'b1111, 1'b1, 4'b0000, 10'd5, rd);
      chk("d_alias_rdata", rd, 32'hDEADBEEF);

      contend(20'h80200, 20'h2A8AA, 20'hFFFFF);
      contend(20'h80000, 20'h2AAAA, 20'hFFCFF);

      d_req = 1'b1; d_addr = 32'h8000_0000; d_we = 1'b1; d_wdata = 32'h5A; d_wstrb = 4'hF;
      step();
      chk("midop_gpio_written", 32'(gpio), 32'h5A);
      rst = 1'b1;
      #1;
      chk("midop_rst_d_ack", 32'(d_ack), 32'd0);
      chk("midop_rst_gpio", 32'(gpio), 32'd0);
      chk("midop_rst_ram_en", 32'(ram_en), 32'd0);
      step();
      chk("midop_rst_d_ack_held", 32'(d_ack), 32'd0);
      rst = 1'b0;
      #1;
      chk("reissue_no_early_ack", 32'(d_ack), 32'd0);
      step();
      chk("reissue_d_ack", 32'(d_ack), 32'd1);
      chk("reissue_gpio", 32'(gpio), 32'h5A);
      d_req = 1'b0;
      step();
      chk("reissue_ack_pulse", 32'(d_ack), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares the core's single-port synchronous RAM between the instruction-fetch port (I) and the load/store port (D) of the `riscv` core. It also decodes a memory-mapped GPIO output register that drives the board `gpio` pins. D has fixed priority over I, with a starvation guard that forces an I grant after a bounded run of D grants. It sits between the core's two bus masters and the RAM macro, inside `riscv`.

## Interface
- `ADDR_W`, 32: address width of both request ports.
- `RAM_WORDS`, 1024: RAM depth in 32-bit words, power of two; `RAM_AW = $clog2(RAM_WORDS)`.
- `STARVE_MAX`, 4: maximum consecutive D grants while I is pending.
- `GPIO_W`, 8: width of the GPIO output register.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `i_req` input 1: fetch request; held high with `i_addr` stable until `i_ack`.
- `i_addr` input ADDR_W: fetch byte address.
- `i_ack` output 1: one-cycle pulse; fetch complete, `i_rdata` valid this cycle.
- `i_rdata` output 32: fetched word.
- `d_req` input 1: data request; held high with all `d_*` inputs stable until `d_ack`.
- `d_addr` input ADDR_W: data byte address.
- `d_we` input 1: 1 = write, 0 = read.
- `d_wdata` input 32: write data.
- `d_wstrb` input 4: byte enables for writes.
- `d_ack` output 1: one-cycle pulse; access complete, `d_rdata` valid for reads.
- `d_rdata` output 32: read data.
- `ram_en` output 1: RAM access strobe.
- `ram_we` output 4: RAM byte write enables; nonzero only with `ram_en`.
- `ram_addr` output RAM_AW: RAM word address.
- `ram_wdata` output 32: RAM write data.
- `ram_rdata` input 32: RAM read data, valid the cycle after `ram_en`.
- `gpio` output GPIO_W: GPIO register value.

## Operation
- FSM states:
  - IDLE: grant decision.
  - BUSY_I: fetch response.
  - BUSY_D: data response.
- Every access is two cycles: an issue cycle in IDLE, then a response cycle in BUSY_x. BUSY_x always returns to IDLE.
- Grant in IDLE, evaluated combinationally from the current requests:
  - `d_req && !(i_req && streak == STARVE_MAX)` grants D.
  - Otherwise `i_req` grants I.
  - Otherwise stay IDLE.
- `streak` counter, width `$clog2(STARVE_MAX+1)`:
  - Increments on a D grant while `i_req` is high.
  - Clears on an I grant, or on a D grant while `i_req` is low.
  - Saturates at STARVE_MAX.
- Address decode:
  - `addr[31] == 1` selects the GPIO register (D port only).
  - Otherwise the access goes to RAM, with `ram_addr = addr[RAM_AW+1:2]`. Upper address bits are ignored (aliasing); `addr[1:0]` is ignored.
- I grant: `ram_en = 1`, `ram_we = 0`, `ram_addr` taken from `i_addr`. An I fetch with `i_addr[31] == 1` also reads RAM (alias); it never reads GPIO.
- D grant to RAM: `ram_en = 1`, `ram_we = d_we ? d_wstrb : 0`, `ram_wdata = d_wdata`.
- D grant to GPIO:
  - `ram_en = 0`.
  - A write with `d_wstrb[0]` loads `gpio <= d_wdata[GPIO_W-1:0]` at the end of the issue cycle.
  - A read latches `gpio`, zero-extended to 32 bits, into a response register.
- Response cycle:
  - BUSY_I: `i_ack = 1`, `i_rdata = ram_rdata`.
  - BUSY_D: `d_ack = 1`, `d_rdata = ram_rdata` for RAM, or the latched GPIO value for GPIO. `d_rdata` is don't-care on writes.
- A requester may present its next request in the cycle after its ack. Because the FSM returns to IDLE first, peak throughput is one access per two cycles.

## Timing
- Reset values: state IDLE, `streak = 0`, `gpio = 0`, `i_ack = d_ack = 0`, `ram_en = 0`, `ram_we = 0`. `ram_en` is forced low while `rst` is high.
- Request latency: ack arrives 2 cycles after the first cycle `req` is seen in IDLE, if granted immediately.
- Simultaneous `i_req` and `d_req` with `streak < STARVE_MAX`: D wins. I waits at most STARVE_MAX D accesses (2×STARVE_MAX cycles) plus its own access.
- STARVE_MAX reached with `i_req` low: D is granted and `streak` clears.
- Reset asserted mid-access: the transaction is dropped and no ack is issued. After reset is released, requesters must re-issue.
- A `req` that deasserts before its ack is a protocol violation. The granted transaction still completes and acks.
- `ram_*` outputs are combinational from state and inputs in IDLE; acks are combinational from state.

## Structure
- Shared package `riscv_pkg`:
  - `arb_state_t` enum {IDLE, BUSY_I, BUSY_D}.
  - `GPIO_SEL_BIT = 31`.
  - `WORD_BYTES = 4`.
- One sub-module, `riscv_gpio_reg`: GPIO register with its write strobe and read latch, async reset to 0.

## Test plan
- Single I fetch: preload RAM[5] = 0xDEADBEEF; `i_req` with `i_addr = 0x14` → `ram_addr = 5` in the issue cycle; `i_ack` with `i_rdata = 0xDEADBEEF` 2 cycles after the request.
- Byte write: D write `d_addr = 0x8`, `d_wstrb = 4'b0010`, `d_wdata = 0x0000AB00` onto RAM[2] = 0 → `ram_we = 4'b0010`; a read of 0x8 returns 0x0000AB00.
- GPIO: D write `d_addr = 0x8000_0000`, `d_wdata = 0xA5` → `gpio = 0xA5` after the issue cycle, `ram_en` stays 0; a read returns 0x000000A5.
- Contention: `i_req` and `d_req` held high continuously → grant order D,D,D,D,I,D,D,D,D,I; `i_ack` at cycles 10 and 20.
- Reset mid-op: assert `rst` in BUSY_D → no `d_ack`, `gpio = 0`, state IDLE; deassert and re-issue → normal 2-cycle ack.
- Idle bus: no requests for 20 cycles → `ram_en`, `i_ack` and `d_ack` stay 0 and `streak` stays 0.
